// File: rtl/scalar_add_issue_pkg.sv
// Shared definitions for the scalar add issue/writeback controller:
// data and register address widths, the 060/061 opcodes, the Sk constant
// used when k=0, and the tag carried alongside each in-flight add.
package scalar_add_issue_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int SREG_AW    = 3;
  localparam int NUM_SREG   = 1 << SREG_AW;

  localparam logic [6:0] OP_SADD = 7'o060;
  localparam logic [6:0] OP_SSUB = 7'o061;

  // Sk operand substituted when k=0: 2^63.
  localparam logic [DATA_WIDTH-1:0] S0_SK_CONST = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic               valid;
    logic [SREG_AW-1:0] addr;
  } tag_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_SADD) || (op == OP_SSUB);
  endfunction

endpackage

// File: rtl/scalar_add_issue_sreg_tag_pipe.sv
// Fixed-depth shift register of {valid, addr} destination tags; shifts every
// clock, never stalls. Ports: clk, rst (async, active high), in_valid/in_addr
// enter stage 0, out_valid/out_addr are the last stage.
module sreg_tag_pipe
  import scalar_add_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [SREG_AW-1:0] in_addr,
  output logic               out_valid,
  output logic [SREG_AW-1:0] out_addr
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    // Address is zeroed on empty slots so the writeback address bus stays quiet.
    stage_d[0].valid = in_valid;
    stage_d[0].addr  = in_valid ? in_addr : '0;
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_addr  = stage_q[DEPTH-1].addr;

endmodule

// File: rtl/scalar_add_issue.sv
// Issue/writeback controller for the scalar add unit (060 add, 061 subtract).
// Ports: issue handshake (i_issue_valid/o_issue_ready, i_instr, i_i/j/k),
// S-file read (o_rd_addr_*, i_rd_data_*), add-unit operands (o_fu_*) and
// result (i_fu_result), S-file write (o_wr_*), reservation bits, illegal pulse.
module scalar_add_issue
  import scalar_add_issue_pkg::*;
#(
  parameter int FU_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_issue_valid,
  input  logic [6:0]            i_instr,
  input  logic [SREG_AW-1:0]    i_i,
  input  logic [SREG_AW-1:0]    i_j,
  input  logic [SREG_AW-1:0]    i_k,
  output logic                  o_issue_ready,
  output logic [SREG_AW-1:0]    o_rd_addr_j,
  output logic [SREG_AW-1:0]    o_rd_addr_k,
  input  logic [DATA_WIDTH-1:0] i_rd_data_j,
  input  logic [DATA_WIDTH-1:0] i_rd_data_k,
  output logic [DATA_WIDTH-1:0] o_fu_sj,
  output logic [DATA_WIDTH-1:0] o_fu_sk,
  output logic [6:0]            o_fu_instr,
  input  logic [DATA_WIDTH-1:0] i_fu_result,
  output logic                  o_wr_en,
  output logic [SREG_AW-1:0]    o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [NUM_SREG-1:0]   o_sreg_busy,
  output logic                  o_illegal
);

  logic [DATA_WIDTH-1:0] fu_sj_q, fu_sj_d;
  logic [DATA_WIDTH-1:0] fu_sk_q, fu_sk_d;
  logic [6:0]            fu_instr_q, fu_instr_d;
  logic [NUM_SREG-1:0]   busy_q, busy_d;
  logic                  illegal_q, illegal_d;

  logic                  issue_ready;
  logic                  accept;
  logic                  accept_op;
  logic                  wb_valid;
  logic [SREG_AW-1:0]    wb_addr;

  // S0 as a source is a constant, never a real dependency, so it is not checked.
  always_comb begin
    issue_ready = 1'b1;
    if (rst)                                issue_ready = 1'b0;
    if (busy_q[i_i])                        issue_ready = 1'b0;
    if ((i_j != '0) && busy_q[i_j])         issue_ready = 1'b0;
    if ((i_k != '0) && busy_q[i_k])         issue_ready = 1'b0;
  end

  assign accept    = i_issue_valid && issue_ready;
  assign accept_op = accept && is_legal_op(i_instr);

  always_comb begin
    fu_sj_d    = fu_sj_q;
    fu_sk_d    = fu_sk_q;
    fu_instr_d = fu_instr_q;
    busy_d     = busy_q;
    illegal_d  = accept && !is_legal_op(i_instr);

    // Clear before set: the same register can never hit both on one edge
    // because ready is held low while its bit is up.
    if (wb_valid) begin
      busy_d[wb_addr] = 1'b0;
    end

    if (accept_op) begin
      fu_sj_d      = (i_j == '0) ? '0 : i_rd_data_j;
      fu_sk_d      = (i_k == '0) ? S0_SK_CONST : i_rd_data_k;
      fu_instr_d   = i_instr;
      busy_d[i_i]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_sj_q    <= '0;
      fu_sk_q    <= '0;
      fu_instr_q <= '0;
      busy_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      fu_sj_q    <= fu_sj_d;
      fu_sk_q    <= fu_sk_d;
      fu_instr_q <= fu_instr_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

  // One extra stage beyond the unit latency: the tag reaches the last stage
  // on the edge the result appears, and writeback is presented for one cycle.
  sreg_tag_pipe #(
    .DEPTH (FU_LATENCY + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_op),
    .in_addr   (i_i),
    .out_valid (wb_valid),
    .out_addr  (wb_addr)
  );

  assign o_issue_ready = issue_ready;
  assign o_rd_addr_j   = i_j;
  assign o_rd_addr_k   = i_k;
  assign o_fu_sj       = fu_sj_q;
  assign o_fu_sk       = fu_sk_q;
  assign o_fu_instr    = fu_instr_q;
  assign o_wr_en       = wb_valid;
  assign o_wr_addr     = wb_addr;
  assign o_wr_data     = i_fu_result;
  assign o_sreg_busy   = busy_q;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_scalar_add_issue.sv
// Testbench for scalar_add_issue: S register file and 3-clock add unit around
// the DUT; an architectural (in-order) model predicts writebacks, busy, ready.
module tb_scalar_add_issue;
  import scalar_add_issue_pkg::*;

  localparam int L = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  i_issue_valid = 1'b0;
  logic [6:0]            i_instr = '0;
  logic [SREG_AW-1:0]    i_i = '0, i_j = '0, i_k = '0;
  logic                  o_issue_ready;
  logic [SREG_AW-1:0]    o_rd_addr_j, o_rd_addr_k;
  logic [DATA_WIDTH-1:0] i_rd_data_j, i_rd_data_k;
  logic [DATA_WIDTH-1:0] o_fu_sj, o_fu_sk;
  logic [6:0]            o_fu_instr;
  logic [DATA_WIDTH-1:0] i_fu_result;
  logic                  o_wr_en;
  logic [SREG_AW-1:0]    o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic [NUM_SREG-1:0]   o_sreg_busy;
  logic                  o_illegal;

  scalar_add_issue #(.FU_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .i_issue_valid(i_issue_valid), .i_instr(i_instr),
    .i_i(i_i), .i_j(i_j), .i_k(i_k), .o_issue_ready(o_issue_ready),
    .o_rd_addr_j(o_rd_addr_j), .o_rd_addr_k(o_rd_addr_k),
    .i_rd_data_j(i_rd_data_j), .i_rd_data_k(i_rd_data_k),
    .o_fu_sj(o_fu_sj), .o_fu_sk(o_fu_sk), .o_fu_instr(o_fu_instr),
    .i_fu_result(i_fu_result), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_sreg_busy(o_sreg_busy), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  // Environment: register file written by the DUT, and the add unit.
  logic [DATA_WIDTH-1:0] env_reg [NUM_SREG];
  logic [DATA_WIDTH-1:0] fu_p1, fu_p2, fu_p3;
  int cyc = 0;

  assign i_rd_data_j = env_reg[i_j];
  assign i_rd_data_k = env_reg[i_k];
  assign i_fu_result = fu_p3;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    fu_p1 <= (o_fu_instr == OP_SSUB) ? (o_fu_sj - o_fu_sk) : (o_fu_sj + o_fu_sk);
    fu_p2 <= fu_p1;
    fu_p3 <= fu_p2;
    if (o_wr_en) env_reg[o_wr_addr] <= o_wr_data;
  end

  // Reference model: sequential architectural state plus reservation windows.
  typedef struct {
    logic [SREG_AW-1:0]    addr;
    logic [DATA_WIDTH-1:0] data;
    int                    cyc;
  } wb_t;

  wb_t                   sb [$];
  logic [DATA_WIDTH-1:0] model_reg [NUM_SREG];
  logic [DATA_WIDTH-1:0] committed [NUM_SREG];
  int                    last_busy [NUM_SREG];
  int                    illegal_cyc = -1;
  logic                  acc_flag = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    for (int r = 0; r < NUM_SREG; r++) begin
      env_reg[r]   = {$urandom(), $urandom()};
      last_busy[r] = -1;
    end
    env_reg[0] = 64'd0;
    env_reg[1] = 64'd5;
    env_reg[2] = 64'd7;
    env_reg[7] = 64'd1;
    for (int r = 0; r < NUM_SREG; r++) begin
      model_reg[r] = env_reg[r];
      committed[r] = env_reg[r];
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [NUM_SREG-1:0]   exp_busy;
    logic                  exp_ready;
    logic [DATA_WIDTH-1:0] a, b, res;
    wb_t                   e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        for (int r = 0; r < NUM_SREG; r++) begin
          last_busy[r] = -1;
          model_reg[r] = committed[r];
        end
        illegal_cyc = -1;
        acc_flag    = 1'b0;
        chk("busy_in_reset", o_sreg_busy, 0);
        chk("ready_in_reset", o_issue_ready, 0);
        chk("wr_en_in_reset", o_wr_en, 0);
      end else begin
        for (int r = 0; r < NUM_SREG; r++) exp_busy[r] = (cyc <= last_busy[r]);
        exp_ready = !exp_busy[i_i] && !((i_j != 0) && exp_busy[i_j]) && !((i_k != 0) && exp_busy[i_k]);
        chk("busy", o_sreg_busy, exp_busy);
        chk("ready", o_issue_ready, exp_ready);
        chk("illegal", o_illegal, (cyc == illegal_cyc));
        chk("rd_addr_j", o_rd_addr_j, i_j);
        chk("rd_addr_k", o_rd_addr_k, i_k);
        if (o_wr_en || (sb.size() > 0 && sb[0].cyc == cyc)) begin
          if (sb.size() == 0) begin
            chk("wb_unexpected", o_wr_en, 0);
          end else begin
            e = sb.pop_front();
            chk("wb_en", o_wr_en, 1);
            chk("wb_addr", o_wr_addr, e.addr);
            chk("wb_data", o_wr_data, e.data);
            chk("wb_cycle", cyc, e.cyc);
            committed[e.addr] = e.data;
          end
        end
        acc_flag = i_issue_valid && exp_ready;
        if (acc_flag) begin
          if (i_instr == 7'o060 || i_instr == 7'o061) begin
            a   = (i_j == 0) ? 64'd0 : model_reg[i_j];
            b   = (i_k == 0) ? 64'h8000_0000_0000_0000 : model_reg[i_k];
            res = (i_instr == 7'o061) ? a - b : a + b;
            e.addr = i_i; e.data = res; e.cyc = cyc + 1 + L;
            sb.push_back(e);
            model_reg[i_i] = res;
            last_busy[i_i] = cyc + 1 + L;
          end else begin
            illegal_cyc = cyc + 1;
          end
        end
      end
    end
  end

  // Present one instruction and hold it until accepted; returns the accept edge.
  task automatic issue(input logic [6:0] op, input int ii, input int jj, input int kk,
                       output int edge_no);
    logic done;
    done = 1'b0;
    edge_no = -1;
    i_issue_valid = 1'b1;
    i_instr = op;
    i_i = SREG_AW'(ii); i_j = SREG_AW'(jj); i_k = SREG_AW'(kk);
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk); #1;
      if (acc_flag) begin
        done = 1'b1;
        edge_no = cyc;
      end
    end
    i_issue_valid = 1'b0;
    if (!done) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    i_issue_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e1, e2, e3, e4;
    #2;
    chk("rst_fu_sj", o_fu_sj, 0);
    chk("rst_fu_sk", o_fu_sk, 0);
    chk("rst_fu_instr", o_fu_instr, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_wr_addr", o_wr_addr, 0);
    chk("rst_busy", o_sreg_busy, 0);
    chk("rst_illegal", o_illegal, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Add, then a dependent add held off by busy[3].
    issue(7'o060, 3, 1, 2, e1);
    issue(7'o060, 5, 3, 1, e2);
    chk("hazard_accept_gap", e2 - e1, 5);
    idle(8);
    chk("add_s3", env_reg[3], 64'd12);
    chk("hazard_s5", env_reg[5], 64'd17);

    // Subtract, with and without the j=0 zero operand.
    issue(7'o061, 4, 1, 2, e1);
    issue(7'o061, 6, 0, 2, e2);
    idle(8);
    chk("sub_s4", env_reg[4], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_j0_s6", env_reg[6], 64'hFFFF_FFFF_FFFF_FFF9);

    // k=0 substitutes 2^63; illegal opcode leaves state untouched.
    issue(7'o060, 3, 7, 0, e1);
    issue(7'o062, 1, 1, 1, e2);
    idle(8);
    chk("k0_s3", env_reg[3], 64'h8000_0000_0000_0001);
    chk("illegal_no_write_s1", env_reg[1], 64'd5);

    // Four independent issues on consecutive cycles.
    issue(7'o060, 1, 7, 7, e1);
    issue(7'o060, 2, 7, 7, e2);
    issue(7'o061, 3, 7, 7, e3);
    issue(7'o060, 4, 7, 0, e4);
    chk("b2b_gap1", e2 - e1, 1);
    chk("b2b_gap2", e3 - e2, 1);
    chk("b2b_gap3", e4 - e3, 1);
    idle(8);

    // Reset one cycle after an accept discards the in-flight write to S6.
    issue(7'o060, 6, 1, 2, e1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    chk("midrst_busy", o_sreg_busy, 0);
    chk("midrst_fu_sj", o_fu_sj, 0);
    #1 rst = 1'b0;
    idle(8);
    chk("midrst_s6_kept", env_reg[6], 64'hFFFF_FFFF_FFFF_FFF9);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 249) == 0);
      i_issue_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) i_instr = 7'($urandom_range(0, 127));
      else                           i_instr = $urandom_range(0, 1) ? OP_SSUB : OP_SADD;
      i_i = SREG_AW'($urandom_range(0, NUM_SREG - 1));
      i_j = SREG_AW'($urandom_range(0, NUM_SREG - 1));
      i_k = SREG_AW'($urandom_range(0, NUM_SREG - 1));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    i_issue_valid = 1'b0;
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
